// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Video timing bundle from vga_timing_gen to its consumers.
//               The master side drives position, syncs, blanking, board-cell
//               decode and the frame counter. The slave side observes them.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int VGA_WIDTH = 12
);
    logic [VGA_WIDTH-1:0] hdata;
    logic [VGA_WIDTH-1:0] vdata;
    logic                 hsync;
    logic                 vsync;
    logic                 data_enable;
    logic                 line_start;
    logic                 frame_start;
    logic [3:0]           cell_x;
    logic [3:0]           cell_y;
    logic                 cell_valid;
    logic [15:0]          frame_count;

    modport master (
        output hdata, vdata, hsync, vsync, data_enable, line_start,
               frame_start, cell_x, cell_y, cell_valid, frame_count
    );

    modport slave (
        input  hdata, vdata, hsync, vsync, data_enable, line_start,
               frame_start, cell_x, cell_y, cell_valid, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator with board-cell decode. All
//               outputs are registered from the *next* raster position, so
//               every output describes the pixel on hdata/vdata.
//               Optional feature macro: VGA_FRAME_COUNTER_EN (enables the
//               16-bit completed-frame counter; otherwise it is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int   VGA_WIDTH = 12,
    parameter int   HSIZE     = 800,
    parameter int   HFP       = 856,
    parameter int   HSP       = 976,
    parameter int   HMAX      = 1040,
    parameter int   VSIZE     = 600,
    parameter int   VFP       = 637,
    parameter int   VSP       = 643,
    parameter int   VMAX      = 666,
    parameter logic HSPP      = 1'b1,
    parameter logic VSPP      = 1'b1,
    parameter int   CELL      = 40,
    parameter int   GRID_ORG  = 40,
    parameter int   GRID_N    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    vga_timing_gen_if.master vga
);

    localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;

    // PRIME: out of reset, the first enabled edge presents (0,0) rather than
    // advancing, so the line/frame pulses for pixel (0,0) are not lost.
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Per-axis board trackers: inside flag, offset inside current cell and a
    // free-running position-mod-CELL counter (grid-line detection).
    logic          in_x;
    logic          in_y;
    logic [CW-1:0] off_x;
    logic [CW-1:0] off_y;
    logic [CW-1:0] mod_x;
    logic [CW-1:0] mod_y;

    logic [VGA_WIDTH-1:0] h_next;
    logic [VGA_WIDTH-1:0] v_next;
    logic                 v_step;
    logic                 in_x_next;
    logic                 in_y_next;
    logic [CW-1:0]        off_x_next;
    logic [CW-1:0]        off_y_next;
    logic [CW-1:0]        mod_x_next;
    logic [CW-1:0]        mod_y_next;
    logic [3:0]           cx_next;
    logic [3:0]           cy_next;
    logic                 cell_valid_next;

    // State register for the prime/run sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_PRIME;
        end else begin
            state <= state_next;
        end
    end

    // Next raster position and next board-tracker state.
    always_comb begin
        state_next = state;
        if (en) begin
            state_next = ST_RUN;
        end

        h_next = vga.hdata;
        v_next = vga.vdata;
        v_step = 1'b0;
        if (state == ST_PRIME) begin
            h_next = '0;
            v_next = '0;
            v_step = 1'b1;
        end else if (vga.hdata == VGA_WIDTH'(HMAX - 1)) begin
            h_next = '0;
            v_step = 1'b1;
            v_next = (vga.vdata == VGA_WIDTH'(VMAX - 1)) ? '0 : vga.vdata + 1'b1;
        end else begin
            h_next = vga.hdata + 1'b1;
        end

        // Horizontal axis: advances every enabled edge.
        mod_x_next = (h_next == '0 || mod_x == CW'(CELL - 1)) ? '0 : mod_x + 1'b1;
        in_x_next  = in_x;
        cx_next    = vga.cell_x;
        off_x_next = off_x;
        if (h_next == VGA_WIDTH'(GRID_ORG)) begin
            in_x_next  = 1'b1;
            cx_next    = '0;
            off_x_next = '0;
        end else if (h_next == '0) begin
            in_x_next  = 1'b0;
            cx_next    = '0;
            off_x_next = '0;
        end else if (in_x) begin
            if (off_x == CW'(CELL - 1)) begin
                off_x_next = '0;
                if (vga.cell_x == 4'(GRID_N - 1)) begin
                    in_x_next = 1'b0;
                    cx_next   = '0;
                end else begin
                    cx_next = vga.cell_x + 4'd1;
                end
            end else begin
                off_x_next = off_x + 1'b1;
            end
        end

        // Vertical axis: advances only when the row changes.
        mod_y_next = mod_y;
        in_y_next  = in_y;
        cy_next    = vga.cell_y;
        off_y_next = off_y;
        if (v_step) begin
            mod_y_next = (v_next == '0 || mod_y == CW'(CELL - 1)) ? '0 : mod_y + 1'b1;
            if (v_next == VGA_WIDTH'(GRID_ORG)) begin
                in_y_next  = 1'b1;
                cy_next    = '0;
                off_y_next = '0;
            end else if (v_next == '0) begin
                in_y_next  = 1'b0;
                cy_next    = '0;
                off_y_next = '0;
            end else if (in_y) begin
                if (off_y == CW'(CELL - 1)) begin
                    off_y_next = '0;
                    if (vga.cell_y == 4'(GRID_N - 1)) begin
                        in_y_next = 1'b0;
                        cy_next   = '0;
                    end else begin
                        cy_next = vga.cell_y + 4'd1;
                    end
                end else begin
                    off_y_next = off_y + 1'b1;
                end
            end
        end

        cell_valid_next = in_x_next && in_y_next &&
                          (mod_x_next != '0) && (mod_y_next != '0);
    end

    // Output and tracker registers: load on enabled edges, hold otherwise;
    // the two start pulses drop whenever en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga.hdata       <= '0;
            vga.vdata       <= '0;
            vga.hsync       <= ~HSPP;
            vga.vsync       <= ~VSPP;
            vga.data_enable <= 1'b0;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.cell_x      <= '0;
            vga.cell_y      <= '0;
            vga.cell_valid  <= 1'b0;
            in_x            <= 1'b0;
            in_y            <= 1'b0;
            off_x           <= '0;
            off_y           <= '0;
            mod_x           <= '0;
            mod_y           <= '0;
        end else if (en) begin
            vga.hdata       <= h_next;
            vga.vdata       <= v_next;
            vga.hsync       <= (h_next >= VGA_WIDTH'(HFP) && h_next < VGA_WIDTH'(HSP)) ? HSPP : ~HSPP;
            vga.vsync       <= (v_next >= VGA_WIDTH'(VFP) && v_next < VGA_WIDTH'(VSP)) ? VSPP : ~VSPP;
            vga.data_enable <= (h_next < VGA_WIDTH'(HSIZE)) && (v_next < VGA_WIDTH'(VSIZE));
            vga.line_start  <= (h_next == '0);
            vga.frame_start <= (h_next == '0) && (v_next == '0);
            vga.cell_x      <= cx_next;
            vga.cell_y      <= cy_next;
            vga.cell_valid  <= cell_valid_next;
            in_x            <= in_x_next;
            in_y            <= in_y_next;
            off_x           <= off_x_next;
            off_y           <= off_y_next;
            mod_x           <= mod_x_next;
            mod_y           <= mod_y_next;
        end else begin
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    // Count frame starts produced by wrap-around; the primed first frame
    // start after reset is deliberately not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga.frame_count <= '0;
        end else if (en && state == ST_RUN && h_next == '0 && v_next == '0) begin
            vga.frame_count <= vga.frame_count + 16'd1;
        end
    end
`else
    assign vga.frame_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen on a scaled-down raster.
//               The driver issues random/directed en and reset stimulus and
//               pushes the expected outputs from an arithmetic raster model;
//               a negedge monitor pops and compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int   T_W     = 12;
    localparam int   T_HSIZE = 64;
    localparam int   T_HFP   = 70;
    localparam int   T_HSP   = 76;
    localparam int   T_HMAX  = 84;
    localparam int   T_VSIZE = 40;
    localparam int   T_VFP   = 43;
    localparam int   T_VSP   = 45;
    localparam int   T_VMAX  = 48;
    localparam logic T_HSPP  = 1'b1;
    localparam logic T_VSPP  = 1'b0;
    localparam int   T_CELL  = 5;
    localparam int   T_ORG   = 5;
    localparam int   T_N     = 6;

    typedef struct {
        int h, v;
        bit hs, vs, de, ls, fs;
        int cx, cy;
        bit cv;
        int fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    vga_timing_gen_if #(.VGA_WIDTH(T_W)) vif ();

    vga_timing_gen #(
        .VGA_WIDTH(T_W),
        .HSIZE(T_HSIZE), .HFP(T_HFP), .HSP(T_HSP), .HMAX(T_HMAX),
        .VSIZE(T_VSIZE), .VFP(T_VFP), .VSP(T_VSP), .VMAX(T_VMAX),
        .HSPP(T_HSPP), .VSPP(T_VSPP),
        .CELL(T_CELL), .GRID_ORG(T_ORG), .GRID_N(T_N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .vga(vif)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model state: raster position, running flag, frames seen.
    bit   running = 1'b0;
    int   px = 0;
    int   py = 0;
    int   frames = 0;
    exp_t cur;

    function automatic exp_t derive(int x, int y, bit ls, bit fs, int fc);
        exp_t e;
        bit bx, by;
        bx = (x >= T_ORG) && (x < T_ORG + T_N * T_CELL);
        by = (y >= T_ORG) && (y < T_ORG + T_N * T_CELL);
        e.h  = x;
        e.v  = y;
        e.hs = (x >= T_HFP && x < T_HSP) ? T_HSPP : !T_HSPP;
        e.vs = (y >= T_VFP && y < T_VSP) ? T_VSPP : !T_VSPP;
        e.de = (x < T_HSIZE) && (y < T_VSIZE);
        e.ls = ls;
        e.fs = fs;
        e.cx = bx ? (x - T_ORG) / T_CELL : 0;
        e.cy = by ? (y - T_ORG) / T_CELL : 0;
        e.cv = bx && by && (x % T_CELL != 0) && (y % T_CELL != 0);
        e.fc = fc;
        return e;
    endfunction

    task automatic model_reset();
        running = 1'b0;
        px = 0;
        py = 0;
        frames = 0;
        cur = derive(0, 0, 1'b0, 1'b0, 0);
        cur.hs = !T_HSPP;
        cur.vs = !T_VSPP;
        cur.de = 1'b0;
        cur.cv = 1'b0;
    endtask

    task automatic model_edge(input bit e, input logic r);
        int fc;
        bit ls, fs;
        if (!r) begin
            model_reset();
        end else if (e) begin
            if (!running) begin
                running = 1'b1;
                px = 0;
                py = 0;
            end else begin
                px++;
                if (px == T_HMAX) begin
                    px = 0;
                    py = (py + 1) % T_VMAX;
                end
            end
            ls = (px == 0);
            fs = (px == 0) && (py == 0);
            if (fs) frames++;
`ifdef VGA_FRAME_COUNTER_EN
            fc = (frames >= 1) ? ((frames - 1) % 65536) : 0;
`else
            fc = 0;
`endif
            cur = derive(px, py, ls, fs, fc);
        end else begin
            cur.ls = 1'b0;
            cur.fs = 1'b0;
        end
    endtask

    // One clock of stimulus: en is set away from the edge, the model follows
    // the edge, optional async reset assert/release happens mid-cycle.
    task automatic cycle(input bit e, input bit rst_mid, input bit rel);
        en = e;
        @(posedge clk);
        model_edge(e, rst_n);
        if (rst_mid) begin
            #2;
            rst_n = 1'b0;
            model_reset();
        end
        if (rel) begin
            #2;
            rst_n = 1'b1;
        end
        sb.push_back(cur);
        #1;
    endtask

    task automatic run_until(input int tx, input int ty, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (running && px == tx && py == ty) return;
        end
        n_assert++;
        n_fail++;
        $display("FAIL %s: target (%0d,%0d) not reached, model at (%0d,%0d)", name, tx, ty, px, py);
    endtask

    // Monitor: every negedge the DUT presents one output set to compare.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL sb_underflow at %0t: no expectation queued", $time);
        end else begin
            e = sb.pop_front();
            n_assert++;
            if (int'(vif.hdata) != e.h || int'(vif.vdata) != e.v ||
                vif.hsync != e.hs || vif.vsync != e.vs ||
                vif.data_enable != e.de || vif.line_start != e.ls ||
                vif.frame_start != e.fs || int'(vif.cell_x) != e.cx ||
                int'(vif.cell_y) != e.cy || vif.cell_valid != e.cv ||
                int'(vif.frame_count) != e.fc) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL sb_compare t=%0t got h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b cx=%0d cy=%0d cv=%0b fc=%0d required h=%0d v=%0d hs=%0b vs=%0b de=%0b ls=%0b fs=%0b cx=%0d cy=%0d cv=%0b fc=%0d",
                             $time, vif.hdata, vif.vdata, vif.hsync, vif.vsync, vif.data_enable,
                             vif.line_start, vif.frame_start, vif.cell_x, vif.cell_y, vif.cell_valid,
                             vif.frame_count, e.h, e.v, e.hs, e.vs, e.de, e.ls, e.fs, e.cx, e.cy,
                             e.cv, e.fc);
            end
        end
    end

    initial begin
        model_reset();

        // Reset held, en toggled: outputs must stay at reset values.
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);

        // One full line plus one: primed (0,0), walk the line, wrap to row 1.
        for (int i = 0; i < T_HMAX + 1; i++) cycle(1'b1, 1'b0, 1'b0);

        // Random en over a bit more than three frames.
        for (int i = 0; i < 16000; i++) cycle($urandom_range(0, 9) < 8, 1'b0, 1'b0);

        // Freeze at last visible column of a visible row, then resume.
        run_until(T_HSIZE - 1, 5, T_HMAX * T_VMAX + 10, "reach_hold_pos");
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a frame, then restart.
        run_until(T_HMAX / 2, T_VMAX / 2, T_HMAX * T_VMAX + 10, "reach_reset_pos");
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2 * T_HMAX * T_VMAX + T_HMAX; i++)
            cycle($urandom_range(0, 15) != 0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
